// File: rtl/vector_display_pkg.sv
// Shared types and defaults for the vector-display pipeline: FSM state
// encoding, default coordinate type and default dwell length.
package vector_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PLOT  = 2'd2
    } state_t;

    localparam int COORD_WIDTH          = 8;
    localparam int DWELL_CYCLES_DEFAULT = 4;

    typedef logic [COORD_WIDTH-1:0] coord_t;

endpackage

// File: rtl/draw_vector_line_if.sv
// Master <-> line rasteriser bundle: go strobe, vector coordinates, busy and
// beam position. o_beam exists only when DRAW_VECTOR_LINE_BEAM_EN is defined.
interface draw_vector_line_if #(
    parameter int OUT_WIDTH = vector_display_pkg::COORD_WIDTH
);
    logic                 go;
    logic [OUT_WIDTH-1:0] i_start_x;
    logic [OUT_WIDTH-1:0] i_start_y;
    logic [OUT_WIDTH-1:0] i_end_x;
    logic [OUT_WIDTH-1:0] i_end_y;
    logic                 busy;
    logic [OUT_WIDTH-1:0] o_x;
    logic [OUT_WIDTH-1:0] o_y;
    logic                 o_valid;
`ifdef DRAW_VECTOR_LINE_BEAM_EN
    logic                 o_beam;

    modport master (
        output go, i_start_x, i_start_y, i_end_x, i_end_y,
        input  busy, o_x, o_y, o_valid, o_beam
    );

    modport slave (
        input  go, i_start_x, i_start_y, i_end_x, i_end_y,
        output busy, o_x, o_y, o_valid, o_beam
    );
`else
    modport master (
        output go, i_start_x, i_start_y, i_end_x, i_end_y,
        input  busy, o_x, o_y, o_valid
    );

    modport slave (
        input  go, i_start_x, i_start_y, i_end_x, i_end_y,
        output busy, o_x, o_y, o_valid
    );
`endif
endinterface

// File: rtl/draw_vector_line_step.sv
// One combinational Bresenham step: next error term and next beam position
// from the current point, plus a flag telling whether the end point is reached.
module draw_vector_line_step
    import vector_display_pkg::*;
#(
    parameter int OUT_WIDTH = COORD_WIDTH
) (
    input  logic signed [OUT_WIDTH+1:0] err,
    input  logic signed [OUT_WIDTH+1:0] dx,
    input  logic signed [OUT_WIDTH+1:0] dy,
    input  logic                        step_x_pos,
    input  logic                        step_y_pos,
    input  logic        [OUT_WIDTH-1:0] cur_x,
    input  logic        [OUT_WIDTH-1:0] cur_y,
    input  logic        [OUT_WIDTH-1:0] end_x,
    input  logic        [OUT_WIDTH-1:0] end_y,
    output logic signed [OUT_WIDTH+1:0] err_next,
    output logic        [OUT_WIDTH-1:0] x_next,
    output logic        [OUT_WIDTH-1:0] y_next,
    output logic                        at_end
);

    logic signed [OUT_WIDTH+1:0] e2;
    logic signed [OUT_WIDTH+1:0] err_acc;

    always_comb begin
        // err stays within [dy, dx], so doubling it still fits OUT_WIDTH+2 bits
        e2      = err <<< 1;
        err_acc = err;
        x_next  = cur_x;
        y_next  = cur_y;
        if (e2 >= dy) begin
            err_acc = err_acc + dy;
            x_next  = step_x_pos ? cur_x + OUT_WIDTH'(1) : cur_x - OUT_WIDTH'(1);
        end
        if (e2 <= dx) begin
            err_acc = err_acc + dx;
            y_next  = step_y_pos ? cur_y + OUT_WIDTH'(1) : cur_y - OUT_WIDTH'(1);
        end
        err_next = err_acc;
        at_end   = (cur_x == end_x) && (cur_y == end_y);
    end

endmodule

// File: rtl/draw_vector_line.sv
// Bresenham line rasteriser: one vector per go, each point held DWELL_CYCLES
// cycles for DAC settling. Optional o_beam output under DRAW_VECTOR_LINE_BEAM_EN.
module draw_vector_line
    import vector_display_pkg::*;
#(
    parameter int OUT_WIDTH    = COORD_WIDTH,
    parameter int DWELL_CYCLES = DWELL_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    draw_vector_line_if.slave bus
);

    localparam int EW  = OUT_WIDTH + 2;
    localparam int DWW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DWW-1:0] DWELL_LOAD = DWW'(DWELL_CYCLES - 1);

    state_t                state_q, state_d;
    logic [OUT_WIDTH-1:0]  sx_q, sx_d, sy_q, sy_d;
    logic [OUT_WIDTH-1:0]  ex_q, ex_d, ey_q, ey_d;
    logic [OUT_WIDTH-1:0]  x_q, x_d, y_q, y_d;
    logic signed [EW-1:0]  dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                  step_x_pos_q, step_x_pos_d;
    logic                  step_y_pos_q, step_y_pos_d;
    logic                  valid_q, valid_d;
    logic [DWW-1:0]        dwell_q, dwell_d;

    logic signed [EW-1:0]  step_err;
    logic [OUT_WIDTH-1:0]  step_x, step_y;
    logic                  at_end;
    logic [EW-1:0]         abs_dx, abs_dy;

    draw_vector_line_step #(
        .OUT_WIDTH (OUT_WIDTH)
    ) u_step (
        .err        (err_q),
        .dx         (dx_q),
        .dy         (dy_q),
        .step_x_pos (step_x_pos_q),
        .step_y_pos (step_y_pos_q),
        .cur_x      (x_q),
        .cur_y      (y_q),
        .end_x      (ex_q),
        .end_y      (ey_q),
        .err_next   (step_err),
        .x_next     (step_x),
        .y_next     (step_y),
        .at_end     (at_end)
    );

    always_comb begin
        abs_dx = (ex_q > sx_q) ? EW'(ex_q) - EW'(sx_q) : EW'(sx_q) - EW'(ex_q);
        abs_dy = (ey_q > sy_q) ? EW'(ey_q) - EW'(sy_q) : EW'(sy_q) - EW'(ey_q);
    end

`ifdef DRAW_VECTOR_LINE_BEAM_EN
    logic beam_q, beam_d;
`endif

    always_comb begin
        state_d      = state_q;
        sx_d         = sx_q;
        sy_d         = sy_q;
        ex_d         = ex_q;
        ey_d         = ey_q;
        x_d          = x_q;
        y_d          = y_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        err_d        = err_q;
        step_x_pos_d = step_x_pos_q;
        step_y_pos_d = step_y_pos_q;
        valid_d      = 1'b0;
        dwell_d      = dwell_q;
`ifdef DRAW_VECTOR_LINE_BEAM_EN
        beam_d       = beam_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.go) begin
                    sx_d    = bus.i_start_x;
                    sy_d    = bus.i_start_y;
                    ex_d    = bus.i_end_x;
                    ey_d    = bus.i_end_y;
                    state_d = SETUP;
`ifdef DRAW_VECTOR_LINE_BEAM_EN
                    // A zero-length vector is a positioning move: keep the beam blanked
                    beam_d  = !((bus.i_start_x == bus.i_end_x) &&
                                (bus.i_start_y == bus.i_end_y));
`endif
                end
            end
            SETUP: begin
                dx_d         = $signed(abs_dx);
                dy_d         = -$signed(abs_dy);
                err_d        = $signed(abs_dx) - $signed(abs_dy);
                step_x_pos_d = (ex_q > sx_q);
                step_y_pos_d = (ey_q > sy_q);
                x_d          = sx_q;
                y_d          = sy_q;
                valid_d      = 1'b1;
                dwell_d      = DWELL_LOAD;
                state_d      = PLOT;
            end
            PLOT: begin
                if (dwell_q != '0) begin
                    dwell_d = dwell_q - DWW'(1);
                end else if (at_end) begin
                    state_d = IDLE;
`ifdef DRAW_VECTOR_LINE_BEAM_EN
                    beam_d  = 1'b0;
`endif
                end else begin
                    err_d   = step_err;
                    x_d     = step_x;
                    y_d     = step_y;
                    valid_d = 1'b1;
                    dwell_d = DWELL_LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sx_q         <= '0;
            sy_q         <= '0;
            ex_q         <= '0;
            ey_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            err_q        <= '0;
            step_x_pos_q <= 1'b0;
            step_y_pos_q <= 1'b0;
            valid_q      <= 1'b0;
            dwell_q      <= '0;
        end else begin
            state_q      <= state_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            ex_q         <= ex_d;
            ey_q         <= ey_d;
            x_q          <= x_d;
            y_q          <= y_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            err_q        <= err_d;
            step_x_pos_q <= step_x_pos_d;
            step_y_pos_q <= step_y_pos_d;
            valid_q      <= valid_d;
            dwell_q      <= dwell_d;
        end
    end

`ifdef DRAW_VECTOR_LINE_BEAM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beam_q <= 1'b0;
        end else begin
            beam_q <= beam_d;
        end
    end

    assign bus.o_beam = beam_q;
`endif

    // busy covers the go cycle itself so the master never sees a gap
    assign bus.busy    = (state_q != IDLE) || bus.go;
    assign bus.o_x     = x_q;
    assign bus.o_y     = y_q;
    assign bus.o_valid = valid_q;

endmodule
